rv32i_alu_arbiter: RTL
======================

Name: rv32i_alu_arbiter

Overview:
- Shares one combinational rv32i_alu instance between two requesters:
  - requester 0: execute-stage address/branch helper;
  - requester 1: CSR/debug compute path.
- Each requester uses a valid/ready handshake. Arbitration is round-robin.
- The selected operands drive the ALU; the result is captured in a one-entry output register with backpressure.
- Fixed latency: one cycle from accept to o_rsp_valid.

Parameters:
- TAG_W, 4: width of the opaque per-request tag returned with the result.

Ports:
- i_clk  in  1  clock; all state on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req0_valid  in  1  requester 0 has an operation.
- o_req0_ready  out  1  requester 0 operation accepted this cycle.
- i_req0_a  in  32  operand a (rs1 or pc).
- i_req0_b  in  32  operand b (rs2 or imm).
- i_req0_op  in  4  ALU opcode.
- i_req0_tag  in  TAG_W  requester 0 tag.
- i_req1_valid, o_req1_ready, i_req1_a, i_req1_b, i_req1_op, i_req1_tag: same as requester 0, for requester 1.
- o_rsp_valid  out  1  result register holds a result.
- i_rsp_ready  in  1  consumer takes the result.
- o_rsp_y  out  32  ALU result.
- o_rsp_id  out  1  index of the requester that produced the result.
- o_rsp_tag  out  TAG_W  tag of that request.
- o_rsp_err  out  1  opcode was outside 0..13; o_rsp_y = 0.

Behaviour:
- Reset (asynchronous, i_rst_n = 0):
  - o_rsp_valid = 0; o_rsp_y = 0; o_rsp_id = 0; o_rsp_tag = 0; o_rsp_err = 0.
  - Round-robin pointer last_grant = 1, so requester 0 wins first.
  - A held result is discarded. Requests in flight are not accepted while reset is low.
- slot_free = !o_rsp_valid | i_rsp_ready. The output register can be refilled in the same cycle it drains.
- Grant (combinational):
  - Only one requester valid: it is granted.
  - Both valid: grant goes to !last_grant.
  - None valid: no grant.
- o_reqN_ready = grant_N & slot_free. At most one ready is high per cycle.
- Accept occurs when reqN_valid & o_reqN_ready. On accept, at the clock edge:
  - capture ALU(a, b, op) into o_rsp_y;
  - capture N into o_rsp_id, the tag into o_rsp_tag, and (op > 13) into o_rsp_err;
  - set o_rsp_valid = 1;
  - set last_grant = N.
- No accept and i_rsp_ready = 1: o_rsp_valid clears. Data fields hold their last values.
- o_rsp_valid = 1 and i_rsp_ready = 0: all output fields remain stable. Both readies are 0.
- The pointer updates only on accept. A valid that is not granted does not move it.
- Requesters must hold valid and payload stable until ready. The block never drops an accepted request.
- Throughput: one result per cycle when i_rsp_ready stays high.
- Starvation bound: with both valid continuously and the consumer always ready, grants alternate 0, 1, 0, 1, ...
- ALU arithmetic is 32-bit with wrap-around. SLT and GE are signed; SLTU and GEU are unsigned. Shifts use b[4:0].

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins when both are valid. last_grant is unused and optimised away. Requester 1 may starve.
- Undefined (default): round-robin as described above.

Decomposition:
- Package rv32i_alu_pkg holds:
  - ALU opcode localparams ADD=0, SUB=1, SLT=2, SLTU=3, XOR=4, OR=5, AND=6, SLL=7, SRL=8, SRA=9, EQ=10, NEQ=11, GE=12, GEU=13;
  - OP_W = 4;
  - OP_MAX = 13.
- Sub-module rv32i_rr_arb2: 2-way grant logic plus last_grant register. Inputs: valids, accept strobe, enable. Output: one-hot grant.
- The existing combinational rv32i_alu is instantiated unchanged.

Test Plan:
- Reset, then req0 only: a=5, b=3, op=SUB, tag=2, consumer ready. Required: o_req0_ready=1; next cycle o_rsp_valid=1, y=2, id=0, tag=2, err=0.
- Both valid continuously for 4 cycles: req0 ADD 1+1, req1 XOR 0xF0^0x0F, consumer ready. Required: grants 0, 1, 0, 1; results 2, 0xFF alternating with matching id.
- Backpressure: result held, i_rsp_ready=0 for 3 cycles with req1 valid. Required: both readies 0; o_rsp_* stable. When i_rsp_ready rises, req1 is accepted that same cycle.
- Signed compares: req1 SLT a=0xFFFFFFFF, b=1 → y=1. SLTU with the same operands → y=0. GE a=0x80000000, b=0 → y=0.
- Illegal op: op=15, a=7, b=9 → y=0, err=1. Next legal op → err=0.
- Async reset asserted while o_rsp_valid=1 and both requesters valid. Required: o_rsp_valid=0 immediately. After release, first grant goes to req0. With ALU_ARB_FIXED_PRIO_EN defined, req0 wins every contended cycle.

Source files
------------

// File: rtl/rv32i_alu_pkg.sv
// Shared ALU opcode encoding for the rv32i ALU and its arbiter.
package rv32i_alu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] ADD  = 4'd0;
  localparam logic [OP_W-1:0] SUB  = 4'd1;
  localparam logic [OP_W-1:0] SLT  = 4'd2;
  localparam logic [OP_W-1:0] SLTU = 4'd3;
  localparam logic [OP_W-1:0] XOR  = 4'd4;
  localparam logic [OP_W-1:0] OR   = 4'd5;
  localparam logic [OP_W-1:0] AND  = 4'd6;
  localparam logic [OP_W-1:0] SLL  = 4'd7;
  localparam logic [OP_W-1:0] SRL  = 4'd8;
  localparam logic [OP_W-1:0] SRA  = 4'd9;
  localparam logic [OP_W-1:0] EQ   = 4'd10;
  localparam logic [OP_W-1:0] NEQ  = 4'd11;
  localparam logic [OP_W-1:0] GE   = 4'd12;
  localparam logic [OP_W-1:0] GEU  = 4'd13;

  localparam logic [OP_W-1:0] OP_MAX = 4'd13;

endpackage

// File: rtl/rv32i_alu.sv
// Combinational 32-bit RV32I ALU; opcodes above OP_MAX yield zero.
module rv32i_alu
  import rv32i_alu_pkg::*;
(
  input  logic [31:0]     a_i,
  input  logic [31:0]     b_i,
  input  logic [OP_W-1:0] op_i,
  output logic [31:0]     y_o
);

  always_comb begin
    y_o = '0;
    case (op_i)
      ADD:     y_o = a_i + b_i;
      SUB:     y_o = a_i - b_i;
      SLT:     y_o = {31'b0, $signed(a_i) < $signed(b_i)};
      SLTU:    y_o = {31'b0, a_i < b_i};
      XOR:     y_o = a_i ^ b_i;
      OR:      y_o = a_i | b_i;
      AND:     y_o = a_i & b_i;
      SLL:     y_o = a_i << b_i[4:0];
      SRL:     y_o = a_i >> b_i[4:0];
      SRA:     y_o = $signed(a_i) >>> b_i[4:0];
      EQ:      y_o = {31'b0, a_i == b_i};
      NEQ:     y_o = {31'b0, a_i != b_i};
      GE:      y_o = {31'b0, $signed(a_i) >= $signed(b_i)};
      GEU:     y_o = {31'b0, a_i >= b_i};
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/rv32i_rr_arb2.sv
// Two-way one-hot grant; round-robin by default, fixed priority to 0 with ALU_ARB_FIXED_PRIO_EN.
// Grant is combinational and forced low when enable_i is low.
module rv32i_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] valid_i,
  input  logic       accept_i,
  input  logic       enable_i,
  output logic [1:0] grant_o
);

  logic prefer1;

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_fixed;
  assign unused_fixed = clk_i ^ rst_ni ^ accept_i;
  assign prefer1 = 1'b0;
`else
  logic last_grant_q, last_grant_d;

  // Favour whoever did not win the last accepted request.
  assign prefer1      = ~last_grant_q;
  assign last_grant_d = accept_i ? grant_o[1] : last_grant_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_grant_q <= 1'b1;
    else         last_grant_q <= last_grant_d;
  end
`endif

  always_comb begin
    grant_o = 2'b00;
    if (enable_i) begin
      case (valid_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        2'b11:   grant_o = prefer1 ? 2'b10 : 2'b01;
        default: grant_o = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/rv32i_alu_arbiter.sv
// Shares one rv32i_alu between two valid/ready requesters; result registered, 1-cycle latency,
// refillable while draining. Define ALU_ARB_FIXED_PRIO_EN for fixed priority to requester 0.
module rv32i_alu_arbiter
  import rv32i_alu_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [31:0]      i_req0_a,
  input  logic [31:0]      i_req0_b,
  input  logic [OP_W-1:0]  i_req0_op,
  input  logic [TAG_W-1:0] i_req0_tag,
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [31:0]      i_req1_a,
  input  logic [31:0]      i_req1_b,
  input  logic [OP_W-1:0]  i_req1_op,
  input  logic [TAG_W-1:0] i_req1_tag,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [31:0]      o_rsp_y,
  output logic             o_rsp_id,
  output logic [TAG_W-1:0] o_rsp_tag,
  output logic             o_rsp_err
);

  logic             slot_free, accept;
  logic [1:0]       grant;
  logic [31:0]      sel_a, sel_b, alu_y;
  logic [OP_W-1:0]  sel_op;
  logic [TAG_W-1:0] sel_tag;

  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_y_q, rsp_y_d;
  logic             rsp_id_q, rsp_id_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic             rsp_err_q, rsp_err_d;

  // Reset low also blocks acceptance so nothing is taken during reset.
  assign slot_free = i_rst_n & (~rsp_valid_q | i_rsp_ready);

  rv32i_rr_arb2 u_arb (
    .clk_i    (i_clk),
    .rst_ni   (i_rst_n),
    .valid_i  ({i_req1_valid, i_req0_valid}),
    .accept_i (accept),
    .enable_i (slot_free),
    .grant_o  (grant)
  );

  assign o_req0_ready = grant[0];
  assign o_req1_ready = grant[1];
  assign accept = (i_req0_valid & o_req0_ready) | (i_req1_valid & o_req1_ready);

  assign sel_a   = grant[1] ? i_req1_a   : i_req0_a;
  assign sel_b   = grant[1] ? i_req1_b   : i_req0_b;
  assign sel_op  = grant[1] ? i_req1_op  : i_req0_op;
  assign sel_tag = grant[1] ? i_req1_tag : i_req0_tag;

  rv32i_alu u_alu (
    .a_i  (sel_a),
    .b_i  (sel_b),
    .op_i (sel_op),
    .y_o  (alu_y)
  );

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_y_d     = rsp_y_q;
    rsp_id_d    = rsp_id_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_err_d   = rsp_err_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_y_d     = alu_y;
      rsp_id_d    = grant[1];
      rsp_tag_d   = sel_tag;
      rsp_err_d   = (sel_op > OP_MAX);
    end else if (i_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_y_q     <= '0;
      rsp_id_q    <= 1'b0;
      rsp_tag_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_y_q     <= rsp_y_d;
      rsp_id_q    <= rsp_id_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_y     = rsp_y_q;
  assign o_rsp_id    = rsp_id_q;
  assign o_rsp_tag   = rsp_tag_q;
  assign o_rsp_err   = rsp_err_q;

endmodule
